// File: rtl/my_ram_8_pkg.sv
// Shared constants and FSM state type for the 8 x 16 RAM and its self-test initiator.
package my_ram_8_pkg;

  localparam int unsigned WIDTH     = 16;
  localparam int unsigned ADDR_BITS = 3;
  localparam int unsigned DEPTH     = 2 ** ADDR_BITS;

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } bist_state_t;

endpackage

// File: rtl/my_ram_8_bist_pattern.sv
// Test pattern generator: seed + address (wrapping), optionally inverted.
module my_ram_8_bist_pattern
  import my_ram_8_pkg::*;
(
  input  logic [WIDTH-1:0]     seed,
  input  logic [ADDR_BITS-1:0] cnt,
  input  logic                 inv,
  output logic [WIDTH-1:0]     expected
);

  logic [WIDTH-1:0] sum_c;

  always_comb begin
    sum_c    = seed + WIDTH'(cnt);
    expected = inv ? ~sum_c : sum_c;
  end

endmodule

// File: rtl/my_ram_8_bist.sv
// Write-then-read self-test initiator for an 8-word x 16-bit RAM.
// Optional second inverted-pattern pass: define MY_RAM_8_BIST_INVERT_PASS_EN.
module my_ram_8_bist
  import my_ram_8_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     seed,
  input  logic [WIDTH-1:0]     ram_out,
  output logic [WIDTH-1:0]     ram_in,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic                 ram_load,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ADDR_BITS-1:0] fail_addr
);

  bist_state_t          state_q, state_d;
  logic [ADDR_BITS-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     seed_q, seed_d;
  logic                 pass_q, pass_d;
  logic [ADDR_BITS-1:0] fail_q, fail_d;
  logic                 inv_c;
  logic [WIDTH-1:0]     expected_c;

`ifdef MY_RAM_8_BIST_INVERT_PASS_EN
  logic inv_q, inv_d;

  always_ff @(posedge clk) begin
    if (!reset_n) inv_q <= 1'b0;
    else          inv_q <= inv_d;
  end

  assign inv_c = inv_q;
`else
  assign inv_c = 1'b0;
`endif

  // One generator feeds both the write data and the read-back compare.
  my_ram_8_bist_pattern u_pattern (
    .seed     (seed_q),
    .cnt      (cnt_q),
    .inv      (inv_c),
    .expected (expected_c)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      seed_q  <= '0;
      pass_q  <= 1'b0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seed_q  <= seed_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seed_d  = seed_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
`ifdef MY_RAM_8_BIST_INVERT_PASS_EN
    inv_d   = inv_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          seed_d  = seed;
          cnt_d   = '0;
          pass_d  = 1'b0;
          fail_d  = '0;
`ifdef MY_RAM_8_BIST_INVERT_PASS_EN
          inv_d   = 1'b0;
`endif
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (cnt_q == LAST_ADDR) begin
          cnt_d   = '0;
          state_d = READ;
        end else begin
          cnt_d = cnt_q + ADDR_BITS'(1);
        end
      end
      READ: begin
        if (ram_out != expected_c) begin
          // First mismatch ends the run; later addresses are never read.
          fail_d  = cnt_q;
          pass_d  = 1'b0;
          state_d = DONE;
        end else if (cnt_q == LAST_ADDR) begin
`ifdef MY_RAM_8_BIST_INVERT_PASS_EN
          if (!inv_q) begin
            inv_d   = 1'b1;
            cnt_d   = '0;
            state_d = WRITE;
          end else begin
            pass_d  = 1'b1;
            state_d = DONE;
          end
`else
          pass_d  = 1'b1;
          state_d = DONE;
`endif
        end else begin
          cnt_d = cnt_q + ADDR_BITS'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM-side outputs decoded from registered state only.
  always_comb begin
    busy      = (state_q == WRITE) || (state_q == READ);
    done      = (state_q == DONE);
    ram_load  = (state_q == WRITE);
    ram_addr  = busy ? cnt_q : '0;
    ram_in    = (state_q == WRITE) ? expected_c : '0;
    pass      = pass_q;
    fail_addr = fail_q;
  end

endmodule

// File: tb/tb_my_ram_8_bist.sv
// Directed bench: BIST paired with a behavioural 8 x 16 RAM that can corrupt one read address.
module tb_my_ram_8_bist;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [15:0] seed;
  logic [15:0] ram_out;
  logic [15:0] ram_in;
  logic [2:0]  ram_addr;
  logic        ram_load;
  logic        busy;
  logic        done;
  logic        pass;
  logic [2:0]  fail_addr;

  logic [15:0] mem [8];
  logic        force_en;
  logic [2:0]  force_addr;
  logic [7:0]  reads_seen;

  int checks = 0;
  int errors = 0;

`ifdef MY_RAM_8_BIST_INVERT_PASS_EN
  localparam logic [15:0] INV_MASK = 16'hFFFF;
  localparam int          LAT      = 32;
`else
  localparam logic [15:0] INV_MASK = 16'h0000;
  localparam int          LAT      = 16;
`endif

  my_ram_8_bist dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .seed      (seed),
    .ram_out   (ram_out),
    .ram_in    (ram_in),
    .ram_addr  (ram_addr),
    .ram_load  (ram_load),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_load) mem[ram_addr] <= ram_in;
    if (busy && !ram_load) reads_seen[ram_addr] <= 1'b1;
  end

  assign ram_out = (force_en && ram_addr == force_addr) ? 16'h0000 : mem[ram_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and park on the following falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Pulse start for one edge; returns in cycle 1 of the run.
  task automatic start_run(input logic [15:0] s);
    seed  = s;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    seed       = 16'd0;
    force_en   = 1'b0;
    force_addr = 3'd0;
    reads_seen = 8'h00;
    for (int i = 0; i < 8; i++) mem[i] = 16'hDEAD;
    step(2);

    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_load", 32'(ram_load), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_in", 32'(ram_in), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_fail", 32'(fail_addr), 32'd0);
    reset_n = 1'b1;
    step(1);

    // Seed 2: writes 2..9, full pass.
    start_run(16'd2);
    chk("t1_c1_busy", 32'(busy), 32'd1);
    chk("t1_c1_load", 32'(ram_load), 32'd1);
    chk("t1_c1_addr", 32'(ram_addr), 32'd0);
    chk("t1_c1_in", 32'(ram_in), 32'd2);
    step(LAT - 1);
    chk("t1_pre_done", 32'(done), 32'd0);
    chk("t1_pre_busy", 32'(busy), 32'd1);
    step(1);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_pass", 32'(pass), 32'd1);
    chk("t1_fail", 32'(fail_addr), 32'd0);
    chk("t1_mem0", 32'(mem[0]), 32'(16'h0002 ^ INV_MASK));
    chk("t1_mem7", 32'(mem[7]), 32'(16'h0009 ^ INV_MASK));

    // Seed FFFE: data wraps through zero.
    start_run(16'hFFFE);
    step(LAT);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_pass", 32'(pass), 32'd1);
    chk("t2_mem0", 32'(mem[0]), 32'(16'hFFFE ^ INV_MASK));
    chk("t2_mem1", 32'(mem[1]), 32'(16'hFFFF ^ INV_MASK));
    chk("t2_mem2", 32'(mem[2]), 32'(16'h0000 ^ INV_MASK));
    chk("t2_mem7", 32'(mem[7]), 32'(16'h0005 ^ INV_MASK));

    // Corrupted read at addr 5, seed 100: early fail.
    force_en   = 1'b1;
    force_addr = 3'd5;
    reads_seen = 8'h00;
    start_run(16'd100);
    step(13);
    chk("t3_rd5_addr", 32'(ram_addr), 32'd5);
    chk("t3_rd5_load", 32'(ram_load), 32'd0);
    chk("t3_rd5_done", 32'(done), 32'd0);
    step(1);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_pass", 32'(pass), 32'd0);
    chk("t3_fail", 32'(fail_addr), 32'd5);
    chk("t3_no_rd67", 32'(reads_seen[7:6]), 32'd0);
    chk("t3_rd0", 32'(reads_seen[0]), 32'd1);
    step(2);
    chk("t3_hold_fail", 32'(fail_addr), 32'd5);
    chk("t3_hold_done", 32'(done), 32'd1);
    force_en = 1'b0;

    // Reset mid-WRITE at cnt 3, then a clean run.
    start_run(16'd9);
    step(3);
    chk("t4_c4_addr", 32'(ram_addr), 32'd3);
    chk("t4_c4_in", 32'(ram_in), 32'd12);
    reset_n = 1'b0;
    step(1);
    chk("t4_rst_busy", 32'(busy), 32'd0);
    chk("t4_rst_load", 32'(ram_load), 32'd0);
    chk("t4_rst_done", 32'(done), 32'd0);
    chk("t4_rst_addr", 32'(ram_addr), 32'd0);
    reset_n = 1'b1;
    start_run(16'd7);
    step(LAT);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_pass", 32'(pass), 32'd1);
    chk("t4_mem7", 32'(mem[7]), 32'(16'h000E ^ INV_MASK));

    // Start held high, seed changed mid-run.
    seed  = 16'd10;
    start = 1'b1;
    step(1);
    step(4);
    seed = 16'd50;
    step(LAT - 5);
    chk("t5_pre_busy", 32'(busy), 32'd1);
    step(1);
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_pass", 32'(pass), 32'd1);
    chk("t5_mem3", 32'(mem[3]), 32'(16'd13 ^ INV_MASK));
    step(1);
    chk("t5_restart_busy", 32'(busy), 32'd1);
    chk("t5_restart_in", 32'(ram_in), 32'd50);
    start = 1'b0;
    step(LAT);
    chk("t5b_done", 32'(done), 32'd1);
    chk("t5b_pass", 32'(pass), 32'd1);
    chk("t5b_mem0", 32'(mem[0]), 32'(16'd50 ^ INV_MASK));
    chk("t5b_mem7", 32'(mem[7]), 32'(16'd57 ^ INV_MASK));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/my_ram_8_bist.md
Name: my_ram_8_bist

Overview:
Self-test initiator that drives the write/read side of an 8-word x 16-bit RAM (addr/in/load in, out back).
- On start: writes a seeded pattern to every address, then reads each address back and compares.
- Reports pass/fail and the first failing address.
- Sits beside the RAM as its only master during test; the surrounding logic muxes it off the RAM when not busy.

Parameters:
WIDTH, 16, data word width
ADDR_BITS, 3, address width; DEPTH = 2**ADDR_BITS words

Ports:
clk  input  1  single clock; RAM writes on clk rising edge when load=1
reset_n  input  1  synchronous, active-low reset, sampled on clk rising edge
start  input  1  begin a test run; sampled in IDLE or DONE only
seed  input  WIDTH  pattern seed, captured when start is accepted
ram_out  input  WIDTH  RAM read data; combinational, equals mem[ram_addr] in the same cycle
ram_in  output  WIDTH  RAM write data
ram_addr  output  ADDR_BITS  RAM address
ram_load  output  1  RAM write enable
busy  output  1  high in WRITE/READ states
done  output  1  high in DONE state; held until the next accepted start
pass  output  1  valid when done=1; 1 = all words matched
fail_addr  output  ADDR_BITS  first mismatching address; valid when done=1 and pass=0, else 0

Behaviour:
- States: IDLE, WRITE, READ, DONE. Registers: state, cnt[ADDR_BITS-1:0], seed_q, pass_q, fail_q.
- Reset (reset_n=0 at an edge) values: state=IDLE, cnt=0, seed_q=0, pass=0, fail_addr=0. Decoded outputs: busy=0, done=0, ram_load=0, ram_addr=0, ram_in=0.
- Reset wins over start at the same edge.
- Reset mid-run returns to IDLE on that edge. RAM contents are left partially written; no cleanup.
- IDLE or DONE, start=1 at an edge: seed_q<=seed, cnt<=0, pass<=0, fail_addr<=0, state<=WRITE. start while busy is ignored.
- WRITE: ram_load=1, ram_addr=cnt, ram_in=seed_q+cnt.
  - Sum is WIDTH-bit, zero-extended cnt, modulo 2**WIDTH (wrap, no carry out).
  - cnt increments each edge; at cnt=DEPTH-1, cnt<=0 and state<=READ.
- READ: ram_load=0, ram_addr=cnt, ram_in=0. Expected value = seed_q+cnt, same width rule.
  - ram_out != expected: fail_addr<=cnt, pass<=0, state<=DONE. The run stops early.
  - Match and cnt=DEPTH-1: pass<=1, state<=DONE.
  - Match otherwise: cnt<=cnt+1.
- DONE: ram_load=0, done=1; pass and fail_addr held.
- Latency, full pass: start accepted at edge E0. WRITE occupies cycles 1..8, READ cycles 9..16, done=1 from cycle 17 (DEPTH=8).
- Latency, early fail: done=1 one cycle after the mismatching READ cycle.
- Seed changes after capture have no effect.
- cnt wraps only by explicit reset to 0 at DEPTH-1; there is never an out-of-range address.

Optional Feature:
Macro: MY_RAM_8_BIST_INVERT_PASS_EN
- Defined: after the first READ completes with no mismatch, run a second WRITE then READ pass using pattern ~(seed_q+cnt).
  - A mod flag selects the pattern.
  - A mismatch in either pass ends the run with that pass's fail_addr.
  - Full-pass latency doubles: done=1 at cycle 33.
- Undefined: single pass only, as above; the flag register does not exist.

Decomposition:
Package my_ram_8_pkg:
- state enum type (IDLE, WRITE, READ, DONE)
- constants WIDTH=16, ADDR_BITS=3, DEPTH=8, shared with my_ram_8
One sub-module: my_ram_8_bist_pattern, combinational, with inputs seed, cnt and inv and output expected word. It is used for both ram_in and the compare.

Test Plan:
- Bench pairs the block with a real my_ram_8: reset, seed=16'd2, start pulse -> ram writes 2..9 at addr 0..7; done=1 at cycle 17, pass=1, fail_addr=0.
- seed=16'hFFFE -> written words FFFE, FFFF, 0000..0005 (wrap); pass=1.
- Behavioural RAM model forces ram_out at addr 5 to 16'h0000, seed=16'd100 -> done one cycle after the addr-5 read, pass=0, fail_addr=3'b101, no reads of addr 6/7.
- Assert reset_n=0 during WRITE at cnt=3 -> next cycle busy=0, ram_load=0, done=0. Then start, seed=16'd7 -> clean run, pass=1.
- start held high throughout a run, seed changed mid-run to 16'd50 -> no restart while busy; compare uses the captured seed; pass=1; after done, start restarts with seed 50.
- With MY_RAM_8_BIST_INVERT_PASS_EN, seed=16'd2 -> second pass writes FFFD..FFF6; done at cycle 33, pass=1.
